// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : State encodings, opcodes and control-word definitions for the
//            multicycle MIPS control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC_R = 3'd3,
        S_WB_R   = 3'd4,
        S_EXEC_I = 3'd5,
        S_WB_I   = 3'd6,
        S_JUMP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;
    localparam logic [2:0] ALU_OP_OR    = 3'b101;
    localparam logic [2:0] ALU_OP_NONE  = 3'b000;

    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP = 2'b10;
    localparam logic       SRC_A_PC    = 1'b0;
    localparam logic       SRC_A_REG   = 1'b1;
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ORI);
`ifdef MC_CTRL_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_output_decode.sv
// ============================================================================
// Module   : mc_ctrl_output_decode
// Brief    : Combinational control-word decode from state, latched opcode and
//            memory-ready. Optional jump support via MC_CTRL_JUMP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_q_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_a = SRC_A_PC;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                // IR and PC load only on the cycle the read data is valid
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.illegal_op = !op_supported(opcode_i);
            end
            S_EXEC_R, S_WB_R: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = ALU_OP_RTYPE;
                ctrl_o.reg_dst   = (state_i == S_WB_R);
                ctrl_o.reg_write = (state_i == S_WB_R);
            end
            S_EXEC_I, S_WB_I: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = (op_q_i == OP_ADDI) ? ALU_OP_ADD : ALU_OP_OR;
                ctrl_o.reg_write = (state_i == S_WB_I);
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PC_SRC_JUMP;
                ctrl_o.alu_op   = ALU_OP_NONE;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Main control FSM of the multicycle MIPS datapath with a
//            retired-instruction counter. MC_CTRL_JUMP_EN adds the J opcode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode_i,
    input  logic               mem_ready_i,
    output logic               mem_read_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_op_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               illegal_op_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [COUNT_W-1:0] count_q, count_d;
    ctrl_t              ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_RTYPE:         state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI:  state_d = S_EXEC_I;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:             state_d = S_JUMP;
`endif
                    // PC was already advanced in FETCH; simply fetch the next word
                    default:          state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_R, S_WB_I: begin
                state_d = S_FETCH;
                count_d = count_q + COUNT_W'(1);
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                state_d = S_FETCH;
                count_d = count_q + COUNT_W'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    mc_ctrl_output_decode u_output_decode (
        .state_i     (state_q),
        .op_q_i      (op_q),
        .opcode_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign mem_read_o    = ctrl.mem_read;
    assign ir_write_o    = ctrl.ir_write;
    assign pc_write_o    = ctrl.pc_write;
    assign pc_src_o      = ctrl.pc_src;
    assign alu_src_a_o   = ctrl.alu_src_a;
    assign alu_src_b_o   = ctrl.alu_src_b;
    assign alu_op_o      = ctrl.alu_op;
    assign reg_dst_o     = ctrl.reg_dst;
    assign reg_write_o   = ctrl.reg_write;
    assign illegal_op_o  = ctrl.illegal_op;
    assign instr_count_o = count_q;

endmodule

`default_nettype wire
